// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives columns, synchronizes/debounces rows, emits one-cycle key strobes.
// Optional digit auto-repeat is compiled in when KEYPAD_KEY_REPEAT_EN is defined.
`timescale 1ns/1ps
module keypad_scanner #(
    parameter int SCAN_DIV        = 16,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_DELAY    = 50000,
    parameter int REPEAT_PERIOD   = 10000
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       digit_strobe,
    output logic       op_strobe,
    output logic [1:0] op_code,
    output logic       equal_strobe,
    output logic       clear_strobe,
    output logic       neg_strobe,
    output logic       key_held
);
    localparam int MAX_A = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int MAX_B = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_P + 1);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {SCAN, DEBOUNCE, EMIT, WAIT_REL, REL_DB} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    col_q, col_d;
    logic [3:0]    pat_q, pat_d;
    logic [3:0]    sync_q, rs;
    logic          one_low;
    logic [1:0]    key_row;
    logic          is_digit, is_op, is_eq, is_clr, is_neg;
    logic [3:0]    digit_val;
    logic          rep_due;

    assign col_out = ~(4'b0001 << col_q);

    always_comb begin
        one_low = 1'b0;
        case (rs)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
            default: one_low = 1'b0;
        endcase
    end

    always_comb begin
        key_row = 2'd3;
        case (pat_q)
            4'b1110: key_row = 2'd0;
            4'b1101: key_row = 2'd1;
            4'b1011: key_row = 2'd2;
            default: key_row = 2'd3;
        endcase
    end

    // Key map decode of the latched (row, column) pair
    always_comb begin
        is_digit  = 1'b0;
        is_op     = 1'b0;
        is_eq     = 1'b0;
        is_clr    = 1'b0;
        is_neg    = 1'b0;
        digit_val = 4'd0;
        if (key_row != 2'd3 && col_q != 2'd3) begin
            is_digit  = 1'b1;
            digit_val = 4'(key_row) * 4'd3 + 4'(col_q) + 4'd1;
        end else if (key_row == 2'd3) begin
            case (col_q)
                2'd0:    is_neg = 1'b1;
                2'd1:    is_digit = 1'b1;
                2'd2:    is_eq = 1'b1;
                default: is_neg = 1'b0;
            endcase
        end else begin
            is_op  = (key_row != 2'd2);
            is_clr = (key_row == 2'd2);
        end
    end

`ifdef KEYPAD_KEY_REPEAT_EN
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);
    logic [CW-1:0] hcnt_q;
    logic          rep_q;

    // hcnt counts cycles since the last EMIT; only digits advance it, so it cannot wrap
    assign rep_due = is_digit && (hcnt_q == (rep_q ? PER_LAST : DLY_LAST));

    always_ff @(posedge clk) begin
        if (!nRST) begin
            hcnt_q <= '0;
            rep_q  <= 1'b0;
        end else begin
            if (state_q == EMIT)
                hcnt_q <= CW'(1);
            else if (state_q == WAIT_REL && is_digit)
                hcnt_q <= hcnt_q + 1'b1;
            if (state_q == DEBOUNCE)
                rep_q <= 1'b0;
            else if (state_q == WAIT_REL && state_d == EMIT)
                rep_q <= 1'b1;
        end
    end
`else
    assign rep_due = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        pat_d   = pat_q;
        case (state_q)
            SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (one_low) begin
                        pat_d   = rs;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (rs != pat_q) begin
                    cnt_d   = '0;
                    state_d = SCAN;
                end else if (cnt_q == DB_LAST) begin
                    cnt_d   = '0;
                    state_d = EMIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EMIT: begin
                cnt_d   = '0;
                state_d = WAIT_REL;
            end
            WAIT_REL: begin
                if (rs == 4'hF) begin
                    cnt_d   = '0;
                    state_d = REL_DB;
                end else if (rep_due) begin
                    state_d = EMIT;
                end
            end
            REL_DB: begin
                if (rs != 4'hF) begin
                    cnt_d   = '0;
                    state_d = WAIT_REL;
                end else if (cnt_q == DB_LAST) begin
                    cnt_d   = '0;
                    col_d   = col_q + 2'd1;
                    state_d = SCAN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            sync_q  <= 4'hF;
            rs      <= 4'hF;
            state_q <= SCAN;
            cnt_q   <= '0;
            col_q   <= 2'd0;
            pat_q   <= 4'hF;
        end else begin
            sync_q  <= row_in;
            rs      <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            pat_q   <= pat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            key_code     <= 4'd0;
            op_code      <= 2'd0;
            digit_strobe <= 1'b0;
            op_strobe    <= 1'b0;
            equal_strobe <= 1'b0;
            clear_strobe <= 1'b0;
            neg_strobe   <= 1'b0;
            key_held     <= 1'b0;
        end else begin
            digit_strobe <= 1'b0;
            op_strobe    <= 1'b0;
            equal_strobe <= 1'b0;
            clear_strobe <= 1'b0;
            neg_strobe   <= 1'b0;
            if (state_q == EMIT) begin
                digit_strobe <= is_digit;
                op_strobe    <= is_op;
                equal_strobe <= is_eq;
                clear_strobe <= is_clr;
                neg_strobe   <= is_neg;
                if (is_digit) key_code <= digit_val;
                if (is_op)    op_code  <= key_row;
            end
            if (state_d == EMIT)
                key_held <= 1'b1;
            else if (state_q == REL_DB && state_d == SCAN)
                key_held <= 1'b0;
        end
    end
endmodule
